uart_rx: RTL and testbench

//   UART receiver, 8N1, LSB first. Complements the uart_trng transmit path.

---
 rtl/uart_rx.sv | 135 +++++++++++++
 tb/tb_uart_rx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 LSB-first UART receiver with valid/ready byte output and sticky framing/overrun flags.
// Latency: valid_o ~CPB*9+HALF+3 clk after the start edge; never stalls, bytes arriving while full are dropped.
module uart_rx #(
  parameter int CLK_FREQ = 10_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       uart_rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);
  localparam logic [CW-1:0] CPB_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            need_idle_q, need_idle_d;
  logic            done_q, done_d;
  logic            bad_q, bad_d;
  logic            rx_meta, rx;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_meta     <= 1'b1;
      rx          <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      need_idle_q <= 1'b0;
      done_q      <= 1'b0;
      bad_q       <= 1'b0;
    end else begin
      rx_meta     <= uart_rx_i;
      rx          <= rx_meta;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      need_idle_q <= need_idle_d;
      done_q      <= done_d;
      bad_q       <= bad_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    need_idle_d = need_idle_q;
    done_d      = 1'b0;
    bad_d       = bad_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // After a low stop bit (break), the line must return high before re-arming.
        if (need_idle_q) begin
          if (rx) need_idle_d = 1'b0;
        end else if (!rx) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CPB_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == CPB_LAST) begin
          cnt_d       = '0;
          done_d      = 1'b1;
          bad_d       = !rx;
          need_idle_d = !rx;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Flag sets are written after the transfer clear so they win in a shared cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_o      <= 8'h00;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      if (valid_o && ready_i) begin
        valid_o     <= 1'b0;
        frame_err_o <= 1'b0;
        overrun_o   <= 1'b0;
      end
      if (done_q) begin
        if (!valid_o || ready_i) begin
          data_o  <= shift_q;
          valid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
        if (bad_q) frame_err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: expected bytes/flags are queued at stimulus time, a monitor checks each handshake.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CLK_FREQ = 10_000_000;
  localparam int BAUD     = 38_400;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int HALF     = CPB / 2;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       uart_rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       overrun_o;

  always #50 clk_i = ~clk_i;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .uart_rx_i   (uart_rx_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       ov;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp    = 0;
  int          n_bad    = 0;
  int          xfer_cnt = 0;
  int unsigned cyc      = 0;
  int unsigned lat_start, lat_meas;
  bit          lat_arm  = 1'b0;
  bit          lat_done = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: every accepted transfer pops one expected entry.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_n_i && valid_o && ready_i) begin
      xfer_cnt++;
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_xfer: got data %0h with empty queue, required no transfer", data_o);
      end else begin
        e = sb_q.pop_front();
        chk("xfer_data", {24'h0, data_o}, {24'h0, e.d});
        chk("xfer_frame_err", {31'h0, frame_err_o}, {31'h0, e.fe});
        chk("xfer_overrun", {31'h0, overrun_o}, {31'h0, e.ov});
      end
    end
    if (lat_arm && valid_o) begin
      lat_meas = cyc - lat_start;
      lat_arm  = 1'b0;
      lat_done = 1'b1;
    end
  end

  task automatic drive_bit(input logic v);
    #1 uart_rx_i = v;
    repeat (CPB) @(posedge clk_i);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v, input bit arm);
    @(posedge clk_i);
    if (arm) begin
      #1;
      lat_start = cyc;
      lat_arm   = 1'b1;
      uart_rx_i = 1'b0;
      repeat (CPB) @(posedge clk_i);
    end else begin
      drive_bit(1'b0);
    end
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_v);
  endtask

  task automatic wait_xfers(input string name, input int n, input int budget);
    for (int i = 0; i < budget && xfer_cnt < n; i++) @(negedge clk_i);
    chk(name, xfer_cnt, n);
  endtask

  initial begin
    #(100 * 80_000);
    $display("FAIL watchdog: simulation did not finish within 80000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    int quiet_bad;
    rst_n_i   = 1'b0;
    uart_rx_i = 1'b1;
    ready_i   = 1'b1;
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_data", {24'h0, data_o}, 32'h00);
    chk("reset_valid", {31'h0, valid_o}, 32'h0);
    chk("reset_frame_err", {31'h0, frame_err_o}, 32'h0);
    chk("reset_overrun", {31'h0, overrun_o}, 32'h0);
    rst_n_i = 1'b1;

    // Idle line for 1 ms.
    quiet_bad = 0;
    repeat (10_000) begin
      @(negedge clk_i);
      if (valid_o || frame_err_o || overrun_o || data_o != 8'h00) quiet_bad++;
    end
    chk("idle_quiet_cycles", quiet_bad, 0);

    // Single byte, also measuring start-edge to valid latency.
    sb_q.push_back('{d: 8'hA5, fe: 1'b0, ov: 1'b0});
    send_byte(8'hA5, 1'b1, 1'b1);
    wait_xfers("xfers_a5", 1, 4 * CPB);
    n_cmp++;
    if (!lat_done || lat_meas < 9 * CPB + HALF + 2 || lat_meas > 9 * CPB + HALF + 4) begin
      n_bad++;
      $display("FAIL latency: got %0d cycles, required %0d..%0d", lat_meas, 9 * CPB + HALF + 2, 9 * CPB + HALF + 4);
    end

    // Back-to-back frames.
    sb_q.push_back('{d: 8'h00, fe: 1'b0, ov: 1'b0});
    sb_q.push_back('{d: 8'hFF, fe: 1'b0, ov: 1'b0});
    send_byte(8'h00, 1'b1, 1'b0);
    send_byte(8'hFF, 1'b1, 1'b0);
    wait_xfers("xfers_00_ff", 3, 4 * CPB);

    // Short low glitch shorter than half a bit.
    @(posedge clk_i);
    #1 uart_rx_i = 1'b0;
    repeat (100) @(posedge clk_i);
    #1 uart_rx_i = 1'b1;
    repeat (2 * CPB) @(posedge clk_i);
    @(negedge clk_i);
    chk("glitch_xfers", xfer_cnt, 3);
    chk("glitch_valid", {31'h0, valid_o}, 32'h0);

    // Framing error: stop bit low.
    sb_q.push_back('{d: 8'h3C, fe: 1'b1, ov: 1'b0});
    send_byte(8'h3C, 1'b0, 1'b0);
    #1 uart_rx_i = 1'b1;
    wait_xfers("xfers_3c", 4, 4 * CPB);
    repeat (2) @(negedge clk_i);
    chk("frame_err_cleared", {31'h0, frame_err_o}, 32'h0);
    chk("valid_after_3c", {31'h0, valid_o}, 32'h0);

    // Overrun: consumer stalled across two frames.
    ready_i = 1'b0;
    sb_q.push_back('{d: 8'h11, fe: 1'b0, ov: 1'b1});
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h22, 1'b1, 1'b0);
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    chk("overrun_data_held", {24'h0, data_o}, 32'h11);
    chk("overrun_valid", {31'h0, valid_o}, 32'h1);
    chk("overrun_flag", {31'h0, overrun_o}, 32'h1);
    chk("overrun_no_frame_err", {31'h0, frame_err_o}, 32'h0);
    @(posedge clk_i);
    #1 ready_i = 1'b1;
    wait_xfers("xfers_11", 5, 10);
    @(negedge clk_i);
    chk("overrun_cleared", {31'h0, overrun_o}, 32'h0);
    chk("valid_after_11", {31'h0, valid_o}, 32'h0);

    // Reset in the middle of 0x55.
    @(posedge clk_i);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    #1;
    rst_n_i   = 1'b0;
    uart_rx_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("midreset_data", {24'h0, data_o}, 32'h00);
    chk("midreset_valid", {31'h0, valid_o}, 32'h0);
    chk("midreset_flags", {30'h0, frame_err_o, overrun_o}, 32'h0);
    rst_n_i = 1'b1;
    repeat (2 * CPB) @(posedge clk_i);
    chk("after_reset_no_xfer", xfer_cnt, 5);

    sb_q.push_back('{d: 8'h66, fe: 1'b0, ov: 1'b0});
    send_byte(8'h66, 1'b1, 1'b0);
    wait_xfers("xfers_66", 6, 4 * CPB);
    repeat (CPB) @(posedge clk_i);
    chk("queue_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
